// File: rtl/mavg_pkg.sv
// mavg_pkg: shared types and helpers for the multi-channel moving-average filter.
//   acc_width()  - running-sum width for a given sample width and window depth
//   mavg_state_e - window state: FILL (count < N) or RUN (count == N)
package mavg_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } mavg_state_e;

  // The sum of 2**log2_n signed data_w-bit samples needs log2_n extra bits.
  function automatic int acc_width(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

endpackage

// File: rtl/mavg_ring.sv
// mavg_ring: single-channel ring of 2**LOG2_N samples, DATA_W bits each.
// The pointer is supplied from outside so that all channels share one.
// Ports:
//   clock     - system clock
//   wr_en_i   - write wr_data_i at ptr_i on the rising edge
//   ptr_i     - shared read/write pointer
//   wr_data_i - sample to store
//   rd_data_o - current contents at ptr_i (combinational, so it is the old
//               value that the same-cycle write is about to replace)
// Storage has no reset; stale contents are masked by the fill count upstream.
module mavg_ring #(
  parameter int DATA_W = 24,
  parameter int LOG2_N = 3
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [LOG2_N-1:0] ptr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<LOG2_N)-1];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[ptr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[ptr_i];

endmodule

// File: rtl/mavg_filter_mc.sv
// mavg_filter_mc: multi-channel boxcar moving-average filter over the last
// 2**LOG2_N samples of each channel, using one full-precision running sum per
// channel and a registered, strobe-qualified output.
// Build option: define MAVG_ROUND_EN for round-half-up output; without it the
// output is the truncating (toward -inf) average. Stored sums are identical.
// Ports:
//   clock, reset - system clock; synchronous active-high reset
//   clear        - synchronous flush of window, sums, fill count and pointer
//   in_valid     - one sample per channel accepted per cycle when high
//   in_data      - channel c at [c*DATA_W +: DATA_W], two's complement
//   out_valid    - one-cycle strobe, out_data holds a fresh average
//   out_data     - per-channel average, same packing as in_data
//   filled       - high while the window holds N samples
//   dbg_state    - current window state, for observation only
// Handshake: no backpressure. Every cycle with in_valid=1 and clear=0 is an
// accept; out_valid pulses exactly one cycle after each accept that leaves the
// window full, and out_data only changes on those pulses (or reset).
module mavg_filter_mc
  import mavg_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int LOG2_N = 3,
  parameter int CH     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 filled,
  output mavg_state_e          dbg_state
);

  localparam int ACC_W = acc_width(DATA_W, LOG2_N);
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] N_CNT = {1'b1, {LOG2_N{1'b0}}};

  mavg_state_e          state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [LOG2_N-1:0]    wr_ptr_q, wr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [CH*DATA_W-1:0] out_data_q, out_data_d;
  logic [CH*DATA_W-1:0] avg_w;
  logic                 accept;

  // clear wins over a coincident sample, which is then dropped.
  assign accept = in_valid & ~clear;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (clear) begin
      state_d  = FILL;
      count_d  = '0;
      wr_ptr_d = '0;
    end else if (in_valid) begin
      wr_ptr_d = wr_ptr_q + LOG2_N'(1);
      case (state_q)
        FILL: begin
          count_d = count_q + CNT_W'(1);
          if (count_d == N_CNT) begin
            state_d = RUN;
          end
        end
        RUN:     count_d = count_q;
        default: state_d = FILL;
      endcase
      if (count_d == N_CNT) begin
        out_valid_d = 1'b1;
        out_data_d  = avg_w;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DATA_W-1:0]       x;
    logic [DATA_W-1:0]       old_raw;
    logic [DATA_W-1:0]       oldest;
    logic signed [ACC_W-1:0] sum_q, sum_d;

    assign x = in_data[c*DATA_W +: DATA_W];

    mavg_ring #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
    ) u_ring (
      .clock     (clock),
      .wr_en_i   (accept & ~reset),
      .ptr_i     (wr_ptr_q),
      .wr_data_i (x),
      .rd_data_o (old_raw)
    );

    // Until the window is full the slot being overwritten holds nothing
    // that is part of the sum.
    assign oldest = (state_q == RUN) ? old_raw : '0;

    assign sum_d = sum_q
                 + $signed({{LOG2_N{x[DATA_W-1]}}, x})
                 - $signed({{LOG2_N{oldest[DATA_W-1]}}, oldest});

    always_ff @(posedge clock) begin
      if (reset || clear) begin
        sum_q <= '0;
      end else if (in_valid) begin
        sum_q <= sum_d;
      end
    end

`ifdef MAVG_ROUND_EN
    // floor((s + 2**(LOG2_N-1)) / 2**LOG2_N) equals floor(s / 2**LOG2_N) plus
    // bit LOG2_N-1 of s, so the half-LSB add reduces to a carry-in on the
    // quotient. A rounded mean of in-range samples is itself in range, so the
    // DATA_W-bit add cannot wrap.
    assign avg_w[c*DATA_W +: DATA_W] = sum_d[ACC_W-1:LOG2_N]
                                     + DATA_W'(sum_d[LOG2_N-1]);
`else
    // ACC_W = DATA_W + LOG2_N, so the upper DATA_W bits of the sum are
    // exactly the low DATA_W bits of sum >>> LOG2_N.
    assign avg_w[c*DATA_W +: DATA_W] = sum_d[ACC_W-1:LOG2_N];
`endif
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign filled    = (state_q == RUN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mavg_filter_mc.sv
// tb_mavg_filter_mc: directed bench for mavg_filter_mc (DATA_W=24, LOG2_N=3,
// CH=2). Accepted samples feed a window model whose averages are queued; a
// monitor on the falling edge pops one entry per out_valid strobe.
module tb_mavg_filter_mc;
  import mavg_pkg::*;

  localparam int DATA_W = 24;
  localparam int LOG2_N = 3;
  localparam int CH     = 2;

  // ---------------- clock / reset / DUT ----------------
  logic                 clock;
  logic                 reset;
  logic                 clear;
  logic                 in_valid;
  logic [CH*DATA_W-1:0] in_data;
  logic                 out_valid;
  logic [CH*DATA_W-1:0] out_data;
  logic                 filled;
  mavg_state_e          dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  mavg_filter_mc #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N),
    .CH     (CH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .filled    (filled),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [CH*DATA_W-1:0] exp_q[$];
  int                   hist0[$];
  int                   hist1[$];
  logic [CH*DATA_W-1:0] last_exp;
  int                   n_checks;
  int                   n_fail;

  function automatic logic [DATA_W-1:0] model_avg(input longint s_in);
    longint            s;
    longint            r;
    logic [DATA_W-1:0] v;
    s = s_in;
`ifdef MAVG_ROUND_EN
    s = s + 4;
`endif
    // Floor division by 8 that is correct for negative sums.
    r = s - (((s % 8) + 8) % 8);
    v = DATA_W'(r / 8);
    return v;
  endfunction

  task automatic check(input string name, input logic [CH*DATA_W-1:0] act,
                       input logic [CH*DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_accept(input int d0, input int d1);
    longint s0;
    longint s1;
    hist0.push_back(d0);
    hist1.push_back(d1);
    if (hist0.size() > 8) begin
      void'(hist0.pop_front());
      void'(hist1.pop_front());
    end
    if (hist0.size() == 8) begin
      s0 = 0;
      s1 = 0;
      foreach (hist0[i]) s0 += hist0[i];
      foreach (hist1[i]) s1 += hist1[i];
      last_exp = {model_avg(s1), model_avg(s0)};
      exp_q.push_back(last_exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic clr, input int d0, input int d1);
    in_valid = v;
    clear    = clr;
    in_data  = {d1[DATA_W-1:0], d0[DATA_W-1:0]};
    if (clr) begin
      hist0.delete();
      hist1.delete();
    end else if (v) begin
      model_accept(d0, d1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [CH*DATA_W-1:0] e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got strobe with data %h, expected no strobe", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_exp = '0;
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_out_valid", {47'd0, out_valid}, 48'd0);
    check("reset_out_data", out_data, 48'd0);
    check("reset_filled", {47'd0, filled}, 48'd0);
    reset = 1'b0;
    idle(2);

    // Constant fill: strobe and filled appear together on the 8th accept.
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 800, -800);
    check("fill7_filled", {47'd0, filled}, 48'd0);
    check("fill7_no_valid", {47'd0, out_valid}, 48'd0);
    drive(1'b1, 1'b0, 800, -800);
    check("fill8_out_valid", {47'd0, out_valid}, 48'd1);
    check("fill8_out_data", out_data, {24'hFFFCE0, 24'h000320});
    check("fill8_filled", {47'd0, filled}, 48'd1);
    check("fill8_state", {47'd0, dbg_state}, {47'd0, RUN});

    // Ramp, gapless, many pointer wraps.
    for (int i = 0; i < 250; i++) drive(1'b1, 1'b0, 200 + i, 1000 - 7 * i);

    // Ramp with random gaps; idle data is junk and must be ignored.
    for (int k = 0; k < 200;) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, 1'b0, 450 + k, -3 * k - 1);
        k++;
      end else begin
        drive(1'b0, 1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      end
    end

    // Clear together with a sample: sample dropped, out_data held.
    drive(1'b1, 1'b1, 9999, 9999);
    check("clear_filled", {47'd0, filled}, 48'd0);
    check("clear_out_valid", {47'd0, out_valid}, 48'd0);
    check("clear_out_hold", out_data, last_exp);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 10 * i, -3 * i);
    check("clear_refill7_filled", {47'd0, filled}, 48'd0);
    drive(1'b1, 1'b0, 70, -21);
    check("clear_refill8_filled", {47'd0, filled}, 48'd1);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 5 * i - 40, 11 * i);

    // Reset mid-run together with a sample.
    in_valid = 1'b1;
    in_data  = {24'h000123, 24'h000456};
    reset    = 1'b1;
    hist0.delete();
    hist1.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset_out_data", out_data, 48'd0);
    check("midreset_filled", {47'd0, filled}, 48'd0);
    check("midreset_out_valid", {47'd0, out_valid}, 48'd0);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 100 + i, -100 - i);
    check("midreset_refill7_filled", {47'd0, filled}, 48'd0);
    for (int i = 7; i < 12; i++) drive(1'b1, 1'b0, 100 + i, -100 - i);

    // Truncation vs rounding.
    drive(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 4, -4);
`ifdef MAVG_ROUND_EN
    check("round_pm4", out_data, {24'h000000, 24'h000001});
`else
    check("trunc_pm4", out_data, {24'hFFFFFF, 24'h000000});
`endif

    // Extremes.
    drive(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, -8388608, 8388607);
    check("extreme_const", out_data, {24'h7FFFFF, 24'h800000});
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) drive(1'b1, 1'b0, 8388607, -8388608);
      else            drive(1'b1, 1'b0, -8388608, 8388607);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8388607, -8388608);
    check("extreme_const_swap", out_data, {24'h800000, 24'h7FFFFF});

    idle(4);
    check("queue_drained", 48'(exp_q.size()), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
